// File: rtl/branch_exec_pipe_if.sv
// Issue/writeback bundle of the two-stage branch execution unit.
// slave = execution unit side, master = issue/writeback side.
interface branch_exec_pipe_if #(
  parameter int XLEN      = 32,
  parameter int WIDTH_REG = 7,
  parameter int WIDTH_BRM = 4
);
  logic                 i_valid;
  logic                 o_ready;
  logic [6:0]           i_uop;
  logic [2:0]           i_func;
  logic [WIDTH_REG-1:0] i_addr;
  logic [XLEN-1:0]      i_PC;
  logic [XLEN-1:0]      i_PCNext;
  logic [XLEN-1:0]      i_imm;
  logic [XLEN-1:0]      i_op1;
  logic [XLEN-1:0]      i_op2;
  logic [WIDTH_BRM-1:0] i_brtag;
  logic [WIDTH_BRM-1:0] i_brmask;
  logic [WIDTH_BRM-1:0] i_kill;
  logic [WIDTH_BRM-1:0] i_clr;
  logic                 i_wb_ready;
  logic                 o_valid;
  logic                 o_we;
  logic [WIDTH_REG-1:0] o_addr;
  logic [XLEN-1:0]      o_data;
  logic [WIDTH_BRM-1:0] o_brmask;
  logic [WIDTH_BRM-1:0] o_brclr;
  logic [WIDTH_BRM-1:0] o_brkill;
  logic                 o_redirect;
  logic [XLEN-1:0]      o_PC;

  modport slave (
    input  i_valid, i_uop, i_func, i_addr, i_PC, i_PCNext, i_imm, i_op1, i_op2,
           i_brtag, i_brmask, i_kill, i_clr, i_wb_ready,
    output o_ready, o_valid, o_we, o_addr, o_data, o_brmask, o_brclr, o_brkill,
           o_redirect, o_PC
  );

  modport master (
    output i_valid, i_uop, i_func, i_addr, i_PC, i_PCNext, i_imm, i_op1, i_op2,
           i_brtag, i_brmask, i_kill, i_clr, i_wb_ready,
    input  o_ready, o_valid, o_we, o_addr, o_data, o_brmask, o_brclr, o_brkill,
           o_redirect, o_PC
  );
endinterface

// File: rtl/branch_exec_pipe.sv
// Two-stage BRANCH/JAL/JALR resolver: link write, tag clear/kill, redirect. Result 2 edges after accept.
// Writeback stall holds R2 stable and backs up into R1; o_ready drops only when both stages are blocked.
module branch_exec_pipe #(
  parameter int XLEN      = 32,
  parameter int WIDTH_REG = 7,
  parameter int WIDTH_BRM = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  branch_exec_pipe_if.slave     io_bus
);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic [6:0]           uop;
    logic [2:0]           func;
    logic [WIDTH_REG-1:0] addr;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      pc_next;
    logic [XLEN-1:0]      imm;
    logic [XLEN-1:0]      op1;
    logic [XLEN-1:0]      op2;
    logic [WIDTH_BRM-1:0] brtag;
    logic [WIDTH_BRM-1:0] brmask;
  } s1_t;

  typedef struct packed {
    logic                 we;
    logic                 mis;
    logic [WIDTH_REG-1:0] addr;
    logic [XLEN-1:0]      data;
    logic [XLEN-1:0]      pc_out;
    logic [WIDTH_BRM-1:0] brtag;
    logic [WIDTH_BRM-1:0] brmask;
  } s2_t;

  logic r_s1_v;
  s1_t  r_s1;
  logic r_s2_v;
  logic r_s2_new;
  s2_t  r_s2;

  logic                 w_adv2;
  logic                 w_s2_kill_now;
  logic                 w_fire;
  logic                 w_in_hit;
  logic                 w_s1_hit;
  logic                 w_s2_hit;
  logic [WIDTH_BRM-1:0] w_k;
  logic [WIDTH_BRM-1:0] w_c;
  logic                 w_is_br;
  logic                 w_is_jal;
  logic                 w_is_jalr;
  logic                 w_cmp;
  logic                 w_taken;
  logic [XLEN-1:0]      w_pc4;
  logic [XLEN-1:0]      w_jalr_sum;
  logic [XLEN-1:0]      w_tgt;
  logic [XLEN-1:0]      w_actual;
  s1_t                  w_s1_in;
  s2_t                  w_s2_in;

  // Resolution pulses fire only on the first R2 cycle and are suppressed if an older branch dies now.
  assign w_s2_kill_now = |(r_s2.brmask & io_bus.i_kill);
  assign w_fire        = r_s2_v & r_s2_new & ~w_s2_kill_now;

  assign io_bus.o_valid    = r_s2_v & ~w_s2_kill_now;
  assign io_bus.o_we       = io_bus.o_valid & r_s2.we;
  assign io_bus.o_addr     = r_s2.addr;
  assign io_bus.o_data     = r_s2.data;
  assign io_bus.o_brmask   = r_s2.brmask;
  assign io_bus.o_PC       = r_s2.pc_out;
  assign io_bus.o_brkill   = (w_fire &  r_s2.mis) ? r_s2.brtag : '0;
  assign io_bus.o_brclr    = (w_fire & ~r_s2.mis) ? r_s2.brtag : '0;
  assign io_bus.o_redirect = w_fire & r_s2.mis;

  assign w_adv2         = ~r_s2_v | io_bus.i_wb_ready;
  assign io_bus.o_ready = ~i_rst & (~r_s1_v | w_adv2);

  // Kill is checked against the uncleared mask so a bit both killed and cleared still kills.
  assign w_k      = io_bus.i_kill | io_bus.o_brkill;
  assign w_c      = io_bus.i_clr  | io_bus.o_brclr;
  assign w_in_hit = |(io_bus.i_brmask & w_k);
  assign w_s1_hit = |(r_s1.brmask & w_k);
  assign w_s2_hit = |(r_s2.brmask & w_k);

  always_comb begin
    w_s1_in         = '0;
    w_s1_in.uop     = io_bus.i_uop;
    w_s1_in.func    = io_bus.i_func;
    w_s1_in.addr    = io_bus.i_addr;
    w_s1_in.pc      = io_bus.i_PC;
    w_s1_in.pc_next = io_bus.i_PCNext;
    w_s1_in.imm     = io_bus.i_imm;
    w_s1_in.op1     = io_bus.i_op1;
    w_s1_in.op2     = io_bus.i_op2;
    w_s1_in.brtag   = io_bus.i_brtag;
    w_s1_in.brmask  = io_bus.i_brmask & ~w_c;
  end

  assign w_is_br   = (r_s1.uop == OP_BRANCH);
  assign w_is_jal  = (r_s1.uop == OP_JAL);
  assign w_is_jalr = (r_s1.uop == OP_JALR);

  always_comb begin
    w_cmp = 1'b0;
    case (r_s1.func)
      3'b000:  w_cmp = (r_s1.op1 == r_s1.op2);
      3'b001:  w_cmp = (r_s1.op1 != r_s1.op2);
      3'b100:  w_cmp = ($signed(r_s1.op1) <  $signed(r_s1.op2));
      3'b101:  w_cmp = ($signed(r_s1.op1) >= $signed(r_s1.op2));
      3'b110:  w_cmp = (r_s1.op1 <  r_s1.op2);
      3'b111:  w_cmp = (r_s1.op1 >= r_s1.op2);
      default: w_cmp = 1'b0;
    endcase
  end

  assign w_taken    = w_is_jal | w_is_jalr | (w_is_br & w_cmp);
  assign w_pc4      = r_s1.pc + XLEN'(4);
  assign w_jalr_sum = r_s1.op1 + r_s1.imm;
  assign w_tgt      = w_is_jalr ? {w_jalr_sum[XLEN-1:1], 1'b0} : (r_s1.pc + r_s1.imm);
  assign w_actual   = w_taken ? w_tgt : w_pc4;

  always_comb begin
    w_s2_in        = '0;
    w_s2_in.we     = (w_is_jal | w_is_jalr) & (|r_s1.addr);
    w_s2_in.mis    = (w_is_br | w_is_jal | w_is_jalr) & (w_actual != r_s1.pc_next);
    w_s2_in.addr   = r_s1.addr;
    w_s2_in.data   = w_pc4;
    w_s2_in.pc_out = w_s2_in.mis ? w_actual : '0;
    w_s2_in.brtag  = r_s1.brtag;
    w_s2_in.brmask = r_s1.brmask & ~w_c;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_v   <= 1'b0;
      r_s1     <= '0;
      r_s2_v   <= 1'b0;
      r_s2_new <= 1'b0;
      r_s2     <= '0;
    end else begin
      if (io_bus.o_ready) begin
        r_s1_v <= io_bus.i_valid & ~w_in_hit;
        if (io_bus.i_valid) begin
          r_s1 <= w_s1_in;
        end
      end else begin
        r_s1_v      <= r_s1_v & ~w_s1_hit;
        r_s1.brmask <= r_s1.brmask & ~w_c;
      end

      if (w_adv2) begin
        r_s2_v   <= r_s1_v & ~w_s1_hit;
        r_s2_new <= r_s1_v & ~w_s1_hit;
        if (r_s1_v) begin
          r_s2 <= w_s2_in;
        end
      end else begin
        r_s2_v      <= r_s2_v & ~w_s2_hit;
        r_s2_new    <= 1'b0;
        r_s2.brmask <= r_s2.brmask & ~w_c;
      end
    end
  end
endmodule

// File: tb/tb_branch_exec_pipe.sv
// Bench for branch_exec_pipe: directed cases from the resolution rules, then randomized traffic
// checked every cycle against a queue-based model of the in-flight ops.
module tb_branch_exec_pipe;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;
  int   n_fail;

  branch_exec_pipe_if #(.XLEN(32), .WIDTH_REG(7), .WIDTH_BRM(4)) bus ();

  branch_exec_pipe #(.XLEN(32), .WIDTH_REG(7), .WIDTH_BRM(4)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  addr;
    logic [3:0]  tag;
    logic [3:0]  mask;
    logic        we;
    logic        mis;
    logic [31:0] data;
    logic [31:0] pcout;
    bit          at_out;
    bit          fresh;
  } op_t;

  op_t        q[$];
  bit         e_adv2;
  bit         e_ready;
  logic [3:0] e_brkill;
  logic [3:0] e_brclr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h (failure #%0d)", tag, obs, exp, n_fail);
    end
  endtask

  // Resolve an op straight from the branch rules.
  function automatic op_t ref_op(input logic [6:0] uop, input logic [2:0] f, input logic [6:0] rd,
                                 input logic [31:0] pc, input logic [31:0] pcn, input logic [31:0] imm,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] tag, input logic [3:0] mask);
    op_t         o;
    bit          ctl;
    bit          taken;
    logic [31:0] target;
    logic [31:0] actual;
    ctl    = 0;
    taken  = 0;
    target = pc + imm;
    if (uop == BR) begin
      ctl = 1;
      case (f)
        3'd0:    taken = (a == b);
        3'd1:    taken = (a != b);
        3'd4:    taken = ($signed(a) <  $signed(b));
        3'd5:    taken = ($signed(a) >= $signed(b));
        3'd6:    taken = (a <  b);
        3'd7:    taken = (a >= b);
        default: taken = 0;
      endcase
    end else if (uop == JAL) begin
      ctl   = 1;
      taken = 1;
    end else if (uop == JALR) begin
      ctl    = 1;
      taken  = 1;
      target = (a + imm) & 32'hFFFF_FFFE;
    end
    actual   = taken ? target : pc + 32'd4;
    o.mis    = ctl && (actual != pcn);
    o.pcout  = o.mis ? actual : 32'd0;
    o.we     = ((uop == JAL) || (uop == JALR)) && (rd != 7'd0);
    o.data   = pc + 32'd4;
    o.addr   = rd;
    o.tag    = tag;
    o.mask   = mask;
    o.at_out = 0;
    o.fresh  = 0;
    return o;
  endfunction

  task automatic check_outputs();
    bit  h;
    bit  ev;
    bit  fire;
    bit  r1occ;
    op_t hd;
    if (rst) begin
      chk("rst_valid",    32'(bus.o_valid),    32'd0);
      chk("rst_ready",    32'(bus.o_ready),    32'd0);
      chk("rst_we",       32'(bus.o_we),       32'd0);
      chk("rst_data",     bus.o_data,          32'd0);
      chk("rst_pc",       bus.o_PC,            32'd0);
      chk("rst_brclr",    32'(bus.o_brclr),    32'd0);
      chk("rst_brkill",   32'(bus.o_brkill),   32'd0);
      chk("rst_redirect", 32'(bus.o_redirect), 32'd0);
      return;
    end
    h  = (q.size() > 0) && q[0].at_out;
    hd = h ? q[0] : ref_op(7'd0, 3'd0, 7'd0, 0, 0, 0, 0, 0, 4'd0, 4'd0);
    ev    = h && ((hd.mask & bus.i_kill) == 4'd0);
    fire  = ev && hd.fresh;
    r1occ = (q.size() == 2) || ((q.size() == 1) && !q[0].at_out);
    e_adv2   = !h || bus.i_wb_ready;
    e_ready  = !r1occ || e_adv2;
    e_brkill = (fire &&  hd.mis) ? hd.tag : 4'd0;
    e_brclr  = (fire && !hd.mis) ? hd.tag : 4'd0;
    chk("valid",    32'(bus.o_valid),    32'(ev));
    chk("ready",    32'(bus.o_ready),    32'(e_ready));
    chk("brkill",   32'(bus.o_brkill),   32'(e_brkill));
    chk("brclr",    32'(bus.o_brclr),    32'(e_brclr));
    chk("redirect", 32'(bus.o_redirect), 32'(fire && hd.mis));
    chk("we",       32'(bus.o_we),       32'(ev && hd.we));
    if (ev) begin
      chk("addr",   32'(bus.o_addr),   32'(hd.addr));
      chk("data",   bus.o_data,        hd.data);
      chk("brmask", 32'(bus.o_brmask), 32'(hd.mask));
      chk("pc",     bus.o_PC,          hd.pcout);
    end
  endtask

  // Advance the in-flight queue across one clock edge.
  task automatic model_step();
    op_t        nq[$];
    op_t        t;
    logic [3:0] k;
    logic [3:0] c;
    if (rst) begin
      q.delete();
      return;
    end
    k = bus.i_kill | e_brkill;
    c = bus.i_clr  | e_brclr;
    foreach (q[i]) begin
      t = q[i];
      if ((t.mask & k) == 4'd0) begin
        t.mask = t.mask & ~c;
        if (t.at_out) begin
          if (!e_adv2) begin
            t.fresh = 0;
            nq.push_back(t);
          end
        end else begin
          if (e_adv2) begin
            t.at_out = 1;
            t.fresh  = 1;
          end
          nq.push_back(t);
        end
      end
    end
    if (bus.i_valid && e_ready && ((bus.i_brmask & k) == 4'd0))
      nq.push_back(ref_op(bus.i_uop, bus.i_func, bus.i_addr, bus.i_PC, bus.i_PCNext, bus.i_imm,
                          bus.i_op1, bus.i_op2, bus.i_brtag, bus.i_brmask & ~c));
    q = nq;
  endtask

  task automatic cycle();
    #1;
    check_outputs();
    model_step();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.i_valid    = 1'b0;
    bus.i_kill     = 4'd0;
    bus.i_clr      = 4'd0;
    bus.i_wb_ready = 1'b1;
  endtask

  task automatic drive_op(input logic [6:0] uop, input logic [2:0] f, input logic [6:0] rd,
                          input logic [31:0] pc, input logic [31:0] pcn, input logic [31:0] imm,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag, input logic [3:0] mask);
    bus.i_valid  = 1'b1;
    bus.i_uop    = uop;
    bus.i_func   = f;
    bus.i_addr   = rd;
    bus.i_PC     = pc;
    bus.i_PCNext = pcn;
    bus.i_imm    = imm;
    bus.i_op1    = a;
    bus.i_op2    = b;
    bus.i_brtag  = tag;
    bus.i_brmask = mask;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return 32'($urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    n_total = 0;
    n_pass  = 0;
    n_fail  = 0;
    rst     = 1'b0;
    drive_idle();
    drive_op(7'd0, 3'd0, 7'd0, 0, 0, 0, 0, 0, 4'd0, 4'd0);
    bus.i_valid = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    cycle();
    rst = 1'b0;
    cycle();

    // BEQ not taken, predicted fall-through
    drive_op(BR, 3'b000, 7'd5, 32'd4, 32'd8, 32'd1, 32'd2, 32'd3, 4'b0010, 4'd0);
    cycle();
    drive_idle();
    cycle();
    #1;
    chk("beq_valid", 32'(bus.o_valid), 32'd1);
    chk("beq_we", 32'(bus.o_we), 32'd0);
    chk("beq_brclr", 32'(bus.o_brclr), 32'b0010);
    chk("beq_redirect", 32'(bus.o_redirect), 32'd0);
    cycle();

    // Same BEQ predicted taken: kill pulse for exactly one cycle
    drive_op(BR, 3'b000, 7'd5, 32'd4, 32'd4, 32'd1, 32'd2, 32'd3, 4'b0010, 4'd0);
    cycle();
    drive_idle();
    cycle();
    bus.i_wb_ready = 1'b0;
    #1;
    chk("beqm_brkill", 32'(bus.o_brkill), 32'b0010);
    chk("beqm_redirect", 32'(bus.o_redirect), 32'd1);
    chk("beqm_pc", bus.o_PC, 32'd8);
    cycle();
    bus.i_wb_ready = 1'b1;
    #1;
    chk("beqm_once", 32'(bus.o_brkill), 32'd0);
    cycle();

    // JAL with link
    drive_op(JAL, 3'b000, 7'd2, 32'd4, 32'h14, 32'h10, 32'd0, 32'd0, 4'b0100, 4'd0);
    cycle();
    drive_idle();
    cycle();
    #1;
    chk("jal_we", 32'(bus.o_we), 32'd1);
    chk("jal_addr", 32'(bus.o_addr), 32'd2);
    chk("jal_data", bus.o_data, 32'd8);
    chk("jal_brclr", 32'(bus.o_brclr), 32'b0100);
    cycle();

    // JALR target has bit 0 cleared
    drive_op(JALR, 3'b000, 7'd1, 32'd0, 32'h40, 32'd2, 32'h21, 32'd0, 4'b1000, 4'd0);
    cycle();
    drive_idle();
    cycle();
    #1;
    chk("jalr_pc", bus.o_PC, 32'h22);
    chk("jalr_brkill", 32'(bus.o_brkill), 32'b1000);
    cycle();

    // BLT signed taken vs BLTU unsigned not taken, both predicted taken
    drive_op(BR, 3'b100, 7'd0, 32'h100, 32'h120, 32'h20, 32'hFFFF_FFFF, 32'd1, 4'b0001, 4'd0);
    cycle();
    drive_op(BR, 3'b110, 7'd0, 32'h100, 32'h120, 32'h20, 32'hFFFF_FFFF, 32'd1, 4'b0010, 4'd0);
    cycle();
    drive_idle();
    #1;
    chk("blt_redirect", 32'(bus.o_redirect), 32'd0);
    chk("blt_brclr", 32'(bus.o_brclr), 32'b0001);
    cycle();
    #1;
    chk("bltu_redirect", 32'(bus.o_redirect), 32'd1);
    chk("bltu_pc", bus.o_PC, 32'h104);
    cycle();

    // Self-kill: mispredicting branch kills the dependent op behind it
    drive_op(BR, 3'b001, 7'd0, 32'h40, 32'h80, 32'h40, 32'd1, 32'd1, 4'b0001, 4'd0);
    cycle();
    drive_op(JAL, 3'b000, 7'd5, 32'h80, 32'h90, 32'h10, 32'd0, 32'd0, 4'b0000, 4'b0001);
    cycle();
    drive_idle();
    #1;
    chk("self_brkill", 32'(bus.o_brkill), 32'b0001);
    cycle();
    #1;
    chk("young_killed", 32'(bus.o_valid), 32'd0);
    cycle();
    #1;
    chk("young_gone", 32'(bus.o_valid), 32'd0);
    cycle();

    // Stall with JAL in R2, then reset mid-stall
    drive_op(JAL, 3'b000, 7'd3, 32'h200, 32'h208, 32'd8, 32'd0, 32'd0, 4'b0010, 4'd0);
    cycle();
    drive_op(BR, 3'b000, 7'd0, 32'h300, 32'h310, 32'h10, 32'd0, 32'd0, 4'b0100, 4'd0);
    bus.i_wb_ready = 1'b0;
    cycle();
    bus.i_valid = 1'b0;
    #1;
    chk("stall_brclr", 32'(bus.o_brclr), 32'b0010);
    chk("stall_ready", 32'(bus.o_ready), 32'd0);
    cycle();
    for (int s = 0; s < 2; s++) begin
      #1;
      chk("stall_valid", 32'(bus.o_valid), 32'd1);
      chk("stall_data", bus.o_data, 32'h204);
      chk("stall_noclr", 32'(bus.o_brclr), 32'd0);
      cycle();
    end
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(bus.o_valid), 32'd0);
    chk("async_rst_data", bus.o_data, 32'd0);
    cycle();
    cycle();
    rst = 1'b0;
    drive_idle();
    drive_op(JAL, 3'b000, 7'd4, 32'h10, 32'h30, 32'h20, 32'd0, 32'd0, 4'b1000, 4'd0);
    cycle();
    drive_idle();
    cycle();
    #1;
    chk("post_rst_we", 32'(bus.o_we), 32'd1);
    chk("post_rst_data", bus.o_data, 32'h14);
    chk("post_rst_brclr", 32'(bus.o_brclr), 32'b1000);
    cycle();

    // Randomized traffic with kills, clears and writeback stalls
    for (int n = 0; n < 2500; n++) begin
      logic [6:0]  u;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] pcn;
      logic [3:0]  tg;
      logic [3:0]  mk;
      case ($urandom_range(0, 3))
        0:       u = BR;
        1:       u = JAL;
        2:       u = JALR;
        default: u = 7'h33;
      endcase
      pc  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
      imm = 32'($urandom_range(0, 64)) - 32'd32;
      a   = pick_val();
      b   = pick_val();
      case ($urandom_range(0, 3))
        0:       pcn = pc + 32'd4;
        1:       pcn = pc + imm;
        2:       pcn = (a + imm) & 32'hFFFF_FFFE;
        default: pcn = $urandom;
      endcase
      tg = ($urandom_range(0, 4) == 0) ? 4'd0 : (4'b0001 << $urandom_range(0, 3));
      mk = ($urandom_range(0, 2) == 0) ? (4'($urandom) & ~tg) : 4'd0;
      drive_op(u, 3'($urandom), 7'($urandom_range(0, 3)), pc, pcn, imm, a, b, tg, mk);
      bus.i_valid    = ($urandom_range(0, 99) < 60);
      bus.i_kill     = ($urandom_range(0, 19) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'd0;
      bus.i_clr      = ($urandom_range(0, 7) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'd0;
      bus.i_wb_ready = ($urandom_range(0, 99) < 70);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
